// File: rtl/saradc_seq_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
package saradc_seq_pkg;

    localparam int RES_W_DEF = 10;
    localparam int ACC_XTRA  = 7;
    localparam int ACC_W     = RES_W_DEF + ACC_XTRA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/saradc_seq_if.sv
// Host/ADC/read-port signal bundle of the sequencer; slave is the sequencer side.
interface saradc_seq_if #(
    parameter int RES_W = saradc_seq_pkg::RES_W_DEF
) ();
    logic             start;
    logic             stop;
    logic             cal_req;
    logic             continuous;
    logic [2:0]       avg_log2;
    logic             clr_err;
    logic             adc_en;
    logic             adc_cal;
    logic             adc_valid;
    logic [RES_W-1:0] adc_result;
    logic             rd_valid;
    logic             rd_ready;
    logic [RES_W-1:0] rd_data;
    logic             avg_valid;
    logic [RES_W-1:0] avg_data;
    logic             busy;
    logic             cal_done;
    logic             overflow;
    logic             timeout_err;

    modport slave (
        input  start, stop, cal_req, continuous, avg_log2, clr_err,
        input  adc_valid, adc_result, rd_ready,
        output adc_en, adc_cal, rd_valid, rd_data, avg_valid, avg_data,
        output busy, cal_done, overflow, timeout_err
    );

    modport master (
        output start, stop, cal_req, continuous, avg_log2, clr_err,
        output adc_valid, adc_result, rd_ready,
        input  adc_en, adc_cal, rd_valid, rd_data, avg_valid, avg_data,
        input  busy, cal_done, overflow, timeout_err
    );
endinterface

// File: rtl/saradc_seq_fifo.sv
// Synchronous show-ahead result FIFO; push on full is dropped unless a pop frees a slot.
module saradc_seq_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en_s;
    logic         rd_en_s;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign wr_en_s = push_i && (!full_o || pop_i);
    assign rd_en_s = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en_s) wr_q <= wr_q + (AW+1)'(1);
            if (rd_en_s) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/saradc_seq.sv
// SAR ADC sequencer: calibration/conversion FSM, valid edge detect, block averaging,
// timeout supervision and a result FIFO toward the host.
module saradc_seq
    import saradc_seq_pkg::*;
#(
    parameter int RES_W      = RES_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CAL_CYCLES = 64,
    parameter int TIMEOUT    = 1023
) (
    input logic          clk,
    input logic          rstn,
    saradc_seq_if.slave  bus
);
    localparam int AW_ACC = RES_W + ACC_XTRA;
    localparam int CW     = $clog2(CAL_CYCLES + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cal_cnt_q, cal_cnt_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [AW_ACC-1:0]  acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         log2_q, log2_d;
    logic               cont_q, cont_d;
    logic               valid_q;
    logic               en_q, cal_q, busy_q, cal_done_q, avg_valid_q, ovf_q, tmo_err_q;
    logic [RES_W-1:0]   avg_data_q;

    logic               edge_s, blk_end_s, fire_s, tmo_hit_s, cal_end_s;
    logic               pop_s, full_s, empty_s;
    logic [AW_ACC-1:0]  sum_s;

    assign edge_s    = (state_q == ST_CONV) && bus.adc_valid && !valid_q;
    assign sum_s     = acc_q + AW_ACC'(bus.adc_result);
    assign blk_end_s = edge_s && ((cnt_q + 8'd1) == (8'd1 << log2_q));
    assign pop_s     = bus.rd_ready && !empty_s;

    // Next-state, counters and accumulator.
    always_comb begin
        state_d   = state_q;
        cal_cnt_d = cal_cnt_q;
        tmo_d     = tmo_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        log2_d    = log2_q;
        cont_d    = cont_q;
        fire_s    = 1'b0;
        tmo_hit_s = 1'b0;
        cal_end_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cal_cnt_d = '0;
                tmo_d     = '0;
                if (bus.cal_req) begin
                    state_d = ST_CAL;
                end else if (bus.start) begin
                    state_d = ST_CONV;
                    log2_d  = bus.avg_log2;
                    cont_d  = bus.continuous;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAL: begin
                if (cal_cnt_q == CW'(CAL_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    cal_end_s = 1'b1;
                end else begin
                    cal_cnt_d = cal_cnt_q + CW'(1);
                end
            end
            ST_CONV: begin
                if (edge_s) tmo_d = '0;
                else        tmo_d = tmo_q + TW'(1);
                // Stop discards the partial block; the FIFO push still happens below.
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                end else if (edge_s) begin
                    if (blk_end_s) begin
                        fire_s = 1'b1;
                        acc_d  = '0;
                        cnt_d  = 8'd0;
                        if (!cont_q) state_d = ST_DONE;
                        else         state_d = ST_CONV;
                    end else begin
                        acc_d = sum_s;
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    tmo_hit_s = 1'b1;
                    state_d   = ST_IDLE;
                    acc_d     = '0;
                    cnt_d     = 8'd0;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cal_cnt_q   <= '0;
            tmo_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            log2_q      <= 3'd0;
            cont_q      <= 1'b0;
            valid_q     <= 1'b0;
            en_q        <= 1'b0;
            cal_q       <= 1'b0;
            busy_q      <= 1'b0;
            cal_done_q  <= 1'b0;
            avg_valid_q <= 1'b0;
            avg_data_q  <= '0;
            ovf_q       <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cal_cnt_q   <= cal_cnt_d;
            tmo_q       <= tmo_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            log2_q      <= log2_d;
            cont_q      <= cont_d;
            valid_q     <= bus.adc_valid;
            en_q        <= (state_d == ST_CAL) || (state_d == ST_CONV);
            cal_q       <= (state_d == ST_CAL);
            busy_q      <= (state_d != ST_IDLE);
            cal_done_q  <= cal_end_s;
            avg_valid_q <= fire_s;
            if (fire_s) avg_data_q <= RES_W'(sum_s >> log2_q);
            // Set events take priority over the clear request.
            if (edge_s && full_s && !pop_s) ovf_q <= 1'b1;
            else if (bus.clr_err)           ovf_q <= 1'b0;
            if (tmo_hit_s)                  tmo_err_q <= 1'b1;
            else if (bus.clr_err)           tmo_err_q <= 1'b0;
        end
    end

    saradc_seq_fifo #(
        .W     (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (edge_s),
        .pop_i   (pop_s),
        .data_i  (bus.adc_result),
        .full_o  (full_s),
        .empty_o (empty_s),
        .data_o  (bus.rd_data)
    );

    assign bus.adc_en      = en_q;
    assign bus.adc_cal     = cal_q;
    assign bus.busy        = busy_q;
    assign bus.cal_done    = cal_done_q;
    assign bus.avg_valid   = avg_valid_q;
    assign bus.avg_data    = avg_data_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout_err = tmo_err_q;
    assign bus.rd_valid    = !empty_s;
endmodule

// File: tb/tb_saradc_seq.sv
// Directed bench for saradc_seq with scoreboard queues for FIFO pops and averages.
module tb_saradc_seq;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    saradc_seq_if #(.RES_W(10)) bus ();

    saradc_seq #(
        .RES_W(10), .FIFO_DEPTH(8), .CAL_CYCLES(64), .TIMEOUT(1023)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         avg_cnt = 0;
    logic [9:0] fifo_q[$];
    logic [9:0] avg_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.adc_en, bus.adc_cal, bus.rd_valid, bus.rd_data, bus.avg_valid,
                    bus.avg_data, bus.busy, bus.cal_done, bus.overflow, bus.timeout_err});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] v, input bit exp_push);
        bus.adc_result = v;
        bus.adc_valid  = 1'b1;
        if (exp_push) fifo_q.push_back(v);
        tick();
        bus.adc_valid  = 1'b0;
    endtask

    // Scoreboard: compare FIFO pops and average pulses against expectations.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.rd_valid && bus.rd_ready) begin
                check("rd_expected", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(fifo_q.pop_front()));
            end
            if (bus.avg_valid) begin
                avg_cnt++;
                check("avg_expected", 32'(avg_q.size() != 0), 32'd1);
                if (avg_q.size() != 0) check("avg_data", 32'(bus.avg_data), 32'(avg_q.pop_front()));
            end
        end
    end

    initial begin
        int hold;
        int n;
        int a0;
        bit seen;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cal_req = 1'b0; bus.continuous = 1'b0;
        bus.avg_log2 = 3'd0; bus.clr_err = 1'b0; bus.adc_valid = 1'b0;
        bus.adc_result = 10'd0; bus.rd_ready = 1'b0;
        repeat (3) tick();
        check("reset_outs", all_outs(), 32'd0);
        rstn = 1'b1;
        tick();

        // 1: calibration
        bus.cal_req = 1'b1; tick(); bus.cal_req = 1'b0;
        hold = 0;
        for (int i = 0; i < 80 && !bus.cal_done; i++) begin
            if (bus.adc_cal && bus.adc_en) hold++;
            tick();
        end
        check("cal_hold_cycles", 32'(hold), 32'd64);
        check("cal_done", 32'(bus.cal_done), 32'd1);
        check("cal_off", 32'({bus.adc_cal, bus.adc_en, bus.busy}), 32'd0);
        tick();
        check("cal_done_pulse", 32'(bus.cal_done), 32'd0);

        // 2: one-shot block of 4
        bus.rd_ready = 1'b1; a0 = avg_cnt;
        bus.avg_log2 = 3'd2; bus.continuous = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("t2_en_on", 32'({bus.adc_en, bus.busy}), 32'd3);
        send(10'd100, 1'b1); tick();
        send(10'd101, 1'b1); tick();
        send(10'd102, 1'b1); tick();
        avg_q.push_back(10'd102);
        send(10'd105, 1'b1);
        check("t2_en_off", 32'(bus.adc_en), 32'd0);
        check("t2_busy_done", 32'(bus.busy), 32'd1);
        tick();
        check("t2_busy_idle", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        check("t2_fifo_drained", 32'(fifo_q.size()), 32'd0);
        check("t2_avg_pulses", 32'(avg_cnt - a0), 32'd1);

        // 3: overflow with no reads
        bus.rd_ready = 1'b0; bus.continuous = 1'b1; bus.avg_log2 = 3'd7;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(10'(200 + i), i < 8);
            if (i == 7) check("t3_no_ovf_at_8", 32'(bus.overflow), 32'd0);
            if (i == 8) check("t3_ovf_at_9", 32'(bus.overflow), 32'd1);
            tick();
        end
        check("t3_rd_valid", 32'(bus.rd_valid), 32'd1);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("t3_stopped", 32'({bus.adc_en, bus.busy}), 32'd0);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 20 && fifo_q.size() != 0; i++) tick();
        tick();
        check("t3_fifo_drained", 32'(fifo_q.size()), 32'd0);
        check("t3_rd_valid_off", 32'(bus.rd_valid), 32'd0);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        check("t3_ovf_clr", 32'(bus.overflow), 32'd0);

        // 4: continuous single-sample blocks, then stop
        a0 = avg_cnt; bus.continuous = 1'b1; bus.avg_log2 = 3'd0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            avg_q.push_back(10'(300 + 7 * i));
            send(10'(300 + 7 * i), 1'b1);
            tick();
        end
        check("t4_avg_pulses", 32'(avg_cnt - a0), 32'd5);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("t4_en_off", 32'(bus.adc_en), 32'd0);
        repeat (3) tick();
        check("t4_fifo_drained", 32'(fifo_q.size()), 32'd0);

        // 5: timeout
        a0 = avg_cnt; bus.continuous = 1'b0; bus.avg_log2 = 3'd1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 1200) begin
            n++;
            tick();
        end
        check("t5_timeout_window", 32'(n >= 1024 && n <= 1025), 32'd1);
        check("t5_timeout_err", 32'(bus.timeout_err), 32'd1);
        check("t5_en_off", 32'(bus.adc_en), 32'd0);
        tick();
        check("t5_no_avg", 32'(avg_cnt - a0), 32'd0);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        check("t5_err_clr", 32'(bus.timeout_err), 32'd0);

        // 6: reset mid-conversion, then simultaneous cal_req/start
        bus.rd_ready = 1'b0; bus.continuous = 1'b1; bus.avg_log2 = 3'd3;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(10'(500 + i), 1'b0);
            tick();
        end
        check("t6_rd_valid_pre", 32'(bus.rd_valid), 32'd1);
        #2 rstn = 1'b0;
        #1 check("t6_async_reset_outs", all_outs(), 32'd0);
        tick();
        rstn = 1'b1;
        check("t6_reset_outs", all_outs(), 32'd0);
        a0 = avg_cnt;
        bus.cal_req = 1'b1; bus.start = 1'b1; bus.continuous = 1'b0;
        tick();
        bus.cal_req = 1'b0; bus.start = 1'b0;
        check("t6_cal_wins", 32'({bus.adc_cal, bus.busy}), 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            seen = bus.cal_done;
        end
        check("t6_cal_done", 32'(seen), 32'd1);
        check("t6_no_conv", 32'({bus.rd_valid, bus.busy}), 32'd0);
        tick();
        check("t6_no_avg", 32'(avg_cnt - a0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
